// File: rtl/packet_assembler_pkg.sv
// rtl/packet_assembler_pkg.sv - shared constants and BCH step function for the data island packet assembler
package packet_assembler_pkg;

  localparam logic [7:0] ECC_POLY    = 8'h83;
  localparam int         PACKET_LEN  = 32;
  localparam int         HEADER_BITS = 24;
  localparam int         SUB_BITS    = 56;
  localparam int         SUB_COUNT   = 4;
  localparam int         CNT_W       = $clog2(PACKET_LEN);

  typedef logic [CNT_W-1:0] cnt_t;

  // Counter values at which each stream switches from data bits to parity bits
  localparam cnt_t HDR_END = cnt_t'(HEADER_BITS);
  localparam cnt_t SUB_END = cnt_t'(SUB_BITS / 2);

  // One serial BCH step: shift right, fold in the polynomial when feedback is set
  function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic b);
    return (ecc >> 1) ^ (((ecc[0] ^ b) == 1'b1) ? ECC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/packet_assembler_bch.sv
// rtl/packet_assembler_bch.sv - serial BCH parity register absorbing one or two bits per cycle
module bch_ecc_serial
  import packet_assembler_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       two_bit_i,
  input  logic [1:0] bits_i,
  output logic [7:0] ecc_o
);

  logic [7:0] ecc_q, ecc_d;
  logic [7:0] base, step1, step2;

  // Clear takes effect on the same cycle's update, so bit 0 is absorbed into a zero register
  always_comb begin
    base  = clr_i ? 8'h00 : ecc_q;
    step1 = bch_step(base, bits_i[0]);
    step2 = bch_step(step1, bits_i[1]);
    ecc_d = ecc_q;
    if (en_i) begin
      ecc_d = two_bit_i ? step2 : step1;
    end else if (clr_i) begin
      ecc_d = 8'h00;
    end
  end

  // Parity register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ecc_q <= 8'h00;
    end else begin
      ecc_q <= ecc_d;
    end
  end

  assign ecc_o = ecc_q;

endmodule

// File: rtl/packet_assembler.sv
// rtl/packet_assembler.sv - serialises an HDMI data island packet with BCH parity onto TERC4 nibbles
module packet_assembler
  import packet_assembler_pkg::*;
(
  input  logic         clk_pixel,
  input  logic         reset,
  input  logic         data_island_period,
  input  logic [23:0]  header,
  input  logic [223:0] sub,
  output logic [8:0]   packet_data,
  output logic         packet_taken
);

  cnt_t                   cnt_q, cnt_d;
  logic [23:0]            hdr_q;
  logic [223:0]           sub_q;
  logic [8:0]             data_q, data_d;
  logic                   start, hdr_phase, sub_phase, ecc_clr;
  logic [23:0]            cur_hdr;
  logic [223:0]           cur_sub;
  logic [7:0]             hdr_ecc;
  logic [SUB_COUNT-1:0][1:0] sub_bits;
  logic [SUB_COUNT-1:0][7:0] sub_ecc;

  // Counter 0 serialises straight from the inputs, since the hold registers load on that same edge
  assign start     = data_island_period && (cnt_q == '0);
  assign hdr_phase = cnt_q < HDR_END;
  assign sub_phase = cnt_q < SUB_END;
  assign ecc_clr   = !data_island_period || (cnt_q == '0);
  assign cur_hdr   = start ? header : hdr_q;
  assign cur_sub   = start ? sub : sub_q;

  assign packet_taken = start && !reset;
  assign packet_data  = data_q;

  // Bit counter: free-runs while the period is high and restarts whenever it drops
  always_comb begin
    cnt_d = data_island_period ? cnt_q + cnt_t'(1) : '0;
  end

  // Counter, hold registers and registered output
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      hdr_q  <= '0;
      sub_q  <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
      if (start) begin
        hdr_q <= header;
        sub_q <= sub;
      end
    end
  end

  bch_ecc_serial u_hdr_ecc (
    .clk_i     (clk_pixel),
    .rst_i     (reset),
    .clr_i     (ecc_clr),
    .en_i      (data_island_period && hdr_phase),
    .two_bit_i (1'b0),
    .bits_i    ({1'b0, cur_hdr[cnt_q]}),
    .ecc_o     (hdr_ecc)
  );

  for (genvar k = 0; k < SUB_COUNT; k++) begin : g_sub
    logic [SUB_BITS-1:0] sub_k;
    assign sub_k       = cur_sub[SUB_BITS*k +: SUB_BITS];
    assign sub_bits[k] = {sub_k[{cnt_q, 1'b1}], sub_k[{cnt_q, 1'b0}]};

    bch_ecc_serial u_sub_ecc (
      .clk_i     (clk_pixel),
      .rst_i     (reset),
      .clr_i     (ecc_clr),
      .en_i      (data_island_period && sub_phase),
      .two_bit_i (1'b1),
      .bits_i    (sub_bits[k]),
      .ecc_o     (sub_ecc[k])
    );
  end

  // Output mux: data bits first, then the frozen parity, zero outside the island
  always_comb begin
    data_d = '0;
    if (data_island_period) begin
      data_d[0] = hdr_phase ? cur_hdr[cnt_q] : hdr_ecc[cnt_q[2:0]];
      for (int k = 0; k < SUB_COUNT; k++) begin
        data_d[1+k] = sub_phase ? sub_bits[k][0] : sub_ecc[k][{cnt_q[1:0], 1'b0}];
        data_d[5+k] = sub_phase ? sub_bits[k][1] : sub_ecc[k][{cnt_q[1:0], 1'b1}];
      end
    end
  end

endmodule

// File: tb/tb_packet_assembler.sv
// tb/tb_packet_assembler.sv - directed self-checking bench for packet_assembler
module tb_packet_assembler;

  logic         clk_pixel = 1'b0;
  logic         reset;
  logic         data_island_period;
  logic [23:0]  header;
  logic [223:0] sub;
  logic [8:0]   packet_data;
  logic         packet_taken;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q [32];

  packet_assembler dut (
    .clk_pixel          (clk_pixel),
    .reset              (reset),
    .data_island_period (data_island_period),
    .header             (header),
    .sub                (sub),
    .packet_data        (packet_data),
    .packet_taken       (packet_taken)
  );

  always #5 clk_pixel = ~clk_pixel;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model_ecc(input logic [63:0] bits, input int n);
    logic [7:0] e;
    logic       fb;
    e = 8'h00;
    for (int i = 0; i < n; i++) begin
      fb = e[0] ^ bits[i];
      e  = {1'b0, e[7:1]};
      if (fb) e = e ^ 8'h83;
    end
    return e;
  endfunction

  task automatic build_expected(input logic [23:0] hdr, input logic [223:0] s);
    logic [7:0]  hecc;
    logic [7:0]  secc [4];
    logic [55:0] sk [4];
    hecc = model_ecc({40'b0, hdr}, 24);
    for (int k = 0; k < 4; k++) begin
      sk[k]   = s[56*k +: 56];
      secc[k] = model_ecc({8'b0, sk[k]}, 56);
    end
    for (int c = 0; c < 32; c++) begin
      exp_q[c][0] = (c < 24) ? hdr[c] : hecc[c-24];
      for (int k = 0; k < 4; k++) begin
        exp_q[c][1+k] = (c < 28) ? sk[k][2*c]   : secc[k][2*(c-28)];
        exp_q[c][5+k] = (c < 28) ? sk[k][2*c+1] : secc[k][2*(c-28)+1];
      end
    end
  endtask

  // Drives ncyc cycles of a packet; inputs are scrambled after cycle 0 to prove the hold registers are used
  task automatic send_packet(input logic [23:0] hdr, input logic [223:0] s, input int ncyc, input string name);
    build_expected(hdr, s);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk_pixel);
      data_island_period = 1'b1;
      header = (c == 0) ? hdr : ~hdr;
      sub    = (c == 0) ? s : ~s;
      #1;
      checks++;
      if (packet_taken !== (c == 0)) begin
        errors++;
        $display("FAIL %s taken cycle %0d: got %b expected %b", name, c, packet_taken, (c == 0));
      end
      @(posedge clk_pixel);
      #1;
      checks++;
      if (packet_data !== exp_q[c]) begin
        errors++;
        $display("FAIL %s data cycle %0d: got %h expected %h", name, c, packet_data, exp_q[c]);
      end
    end
  endtask

  task automatic idle_cycle(input string name);
    @(negedge clk_pixel);
    data_island_period = 1'b0;
    #1;
    checks++;
    if (packet_taken !== 1'b0) begin
      errors++;
      $display("FAIL %s idle taken: got %b expected 0", name, packet_taken);
    end
    @(posedge clk_pixel);
    #1;
    checks++;
    if (packet_data !== 9'd0) begin
      errors++;
      $display("FAIL %s idle data: got %h expected 000", name, packet_data);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    data_island_period = 1'b1;
    header = 24'hFFFFFF;
    sub = '1;
    repeat (2) @(posedge clk_pixel);
    #1;
    checks++;
    if (packet_data !== 9'd0) begin
      errors++;
      $display("FAIL reset data: got %h expected 000", packet_data);
    end
    checks++;
    if (packet_taken !== 1'b0) begin
      errors++;
      $display("FAIL reset taken: got %b expected 0", packet_taken);
    end
    @(negedge clk_pixel);
    data_island_period = 1'b0;
    reset = 1'b0;
    idle_cycle("post_reset");
  endtask

  task automatic test_null_packet();
    send_packet(24'h0, 224'h0, 32, "null");
    idle_cycle("null");
  endtask

  // Hand-computed stream: header bit 0 set, parity 8'h4A sent LSB first
  task automatic test_header_bit0();
    logic [7:0] hecc;
    logic [8:0] want;
    hecc = 8'h4A;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk_pixel);
      data_island_period = 1'b1;
      header = (c == 0) ? 24'h000001 : 24'h0;
      sub = '0;
      @(posedge clk_pixel);
      #1;
      want = '0;
      if (c == 0) want[0] = 1'b1;
      else if (c >= 24) want[0] = hecc[c-24];
      checks++;
      if (packet_data !== want) begin
        errors++;
        $display("FAIL hdr_bit0 cycle %0d: got %h expected %h", c, packet_data, want);
      end
    end
    idle_cycle("hdr_bit0");
  endtask

  task automatic test_sub0_bit0();
    send_packet(24'h0, 224'h1, 32, "sub0_bit0");
    idle_cycle("sub0_bit0");
  endtask

  task automatic test_back_to_back();
    send_packet(24'hA5C31E, {56'hDEADBEEF012345, 56'h13579BDF2468AC, 56'h00FF00FF00FF00, 56'h8000000000001F}, 32, "b2b_first");
    send_packet(24'h3C5A96, {56'h0123456789ABCD, 56'hFEDCBA98765432, 56'h5A5A5A5A5A5A5A, 56'hC3C3C3C3C3C3C3}, 32, "b2b_second");
    idle_cycle("b2b");
  endtask

  task automatic test_abandon();
    send_packet(24'h7E1234, {4{56'hAAAAAAAAAAAAAA}}, 13, "abandon_part");
    idle_cycle("abandon_gap");
    idle_cycle("abandon_gap2");
    send_packet(24'h0F0F0F, {56'h11111111111111, 56'h22222222222222, 56'h44444444444444, 56'h88888888888888}, 32, "abandon_new");
    idle_cycle("abandon_new");
  endtask

  task automatic test_reset_mid();
    send_packet(24'hFFFFFF, '1, 20, "rst_part");
    @(negedge clk_pixel);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (packet_data !== 9'd0) begin
      errors++;
      $display("FAIL rst_mid async data: got %h expected 000", packet_data);
    end
    checks++;
    if (packet_taken !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid taken: got %b expected 0", packet_taken);
    end
    @(negedge clk_pixel);
    data_island_period = 1'b0;
    reset = 1'b0;
    send_packet(24'h9A0C51, {56'hCAFEF00DBAADC0, 56'h0000000000F00D, 56'h7777777777777, 56'h1}, 32, "rst_after");
    idle_cycle("rst_after");
  endtask

  initial begin
    test_reset();
    test_null_packet();
    test_header_bit0();
    test_sub0_bit0();
    test_back_to_back();
    test_abandon();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/packet_assembler.md
PACKET_ASSEMBLER -- requirements
Module: packet_assembler

Interface
REQ-001 SHALL have parameter: none; all widths fixed by HDMI data island packet format.
REQ-002 SHALL have port clk_pixel  in  1  pixel clock, sole clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port data_island_period  in  1  high while the data island period is active, one packet per 32 consecutive high cycles.
REQ-005 SHALL have port header  in  24  packet header HB2..HB0, bit 0 sent first.
REQ-006 SHALL have port sub  in  224  subpackets 3..0, each 56 bits, sub[56*k +: 56] = subpacket k.
REQ-007 SHALL have port packet_data  out  9  bit 0 = channel 0 bit 2, bits [4:1] = channel 1 bits [3:0], bits [8:5] = channel 2 bits [3:0].
REQ-008 SHALL have port packet_taken  out  1  one-cycle pulse when the current inputs have been latched, so upstream may present the next packet.

Function
REQ-009 SHALL keep a 5-bit counter, 0..31, incrementing each cycle data_island_period is high, wrapping 31 -> 0.
REQ-010 SHALL latch header and sub into hold registers on cycles where data_island_period is high and counter == 0; packet_taken SHALL be high in exactly those cycles.
REQ-011 SHALL register packet_data: the value for bit index counter appears one cycle after that counter value (latency 1).
REQ-012 Header: counter 0..23 SHALL output header bit [counter]; counter 24..31 SHALL output header ECC bit [counter-24], LSB first.
REQ-013 Subpacket k: counter 0..27 SHALL output even bit sub_k[2*counter] on bit 1+k and odd bit sub_k[2*counter+1] on bit 5+k.
REQ-014 Subpacket k: counter 28..31 SHALL output ECC_k[2*(counter-28)] on bit 1+k and ECC_k[2*(counter-28)+1] on bit 5+k.
REQ-015 ECC SHALL be BCH, one 8-bit register per stream, cleared at counter 0, updated per data bit b: next = (ecc >> 1) XOR (ecc[0] XOR b ? 8'h83 : 8'h00).
REQ-016 Subpacket ECC SHALL absorb the even bit, then the odd bit, in the same cycle, two updates per cycle.
REQ-017 ECC registers SHALL freeze during their emission cycles and not be updated by emitted parity bits.
REQ-018 When data_island_period is low, packet_data SHALL be 9'd0 on the next cycle, and the counter and ECC SHALL return to 0.
REQ-019 When data_island_period falls with counter != 0, the partial packet SHALL be abandoned with no flag, and the next rise SHALL start a fresh packet at counter 0.
REQ-020 Back-to-back packets, with data_island_period high for 64 cycles, SHALL latch at counter 0 twice with no gap cycle.

Reset
REQ-021 Reset SHALL asynchronously set counter = 0, ECC registers = 0, hold registers = 0, packet_data = 9'd0, packet_taken = 0.
REQ-022 Reset asserted mid-packet SHALL abort the packet; after release the first high data_island_period cycle SHALL be counter 0.

Structure
REQ-023 A shared package SHALL hold the constants ECC polynomial 8'h83, packet length 32, header data bits 24, subpacket data bits 56, and subpacket count 4.
REQ-024 SHALL instantiate one sub-module, bch_ecc_serial: 8-bit register with clear, an enable, and a 1- or 2-bit update input.
REQ-025 There SHALL be five instances of bch_ecc_serial: one for the header and one per subpacket.

Verification
REQ-026 NULL packet (header=0, sub=0), period high 32 cycles -> packet_data all 9'd0, packet_taken pulses once at cycle 0.
REQ-027 header=24'h000001, sub=0 -> packet_data[0] = 1 at output cycle 0 and 0 for cycles 1..23; header ECC = 8'h4A, emitted on cycles 24..31 as 0,1,0,1,0,0,1,0.
REQ-028 sub0 = 56'h1 -> packet_data[1] = 1 at output cycle 0 and packet_data[5] = 0 throughout data cycles; ECC_0 matches the bench model with the REQ-015 rule applied to 56 bits.
REQ-029 period high 64 cycles with two distinct random packets -> two packet_taken pulses 32 cycles apart, and both packets match the bench model.
REQ-030 period drops at counter 13, then rises again -> output 0 during the gap, counter restarts at 0, a new latch occurs, and ECC is correct for the new packet.
REQ-031 reset asserted at counter 20 -> outputs 0 immediately without waiting for a clock, and the next packet after release is fully correct.
